// File: rtl/frame_burst_writer_if.sv
// Pixel stream plus MCB user write/command port bundle for frame_burst_writer.
// The block takes the slave side; the render engine / MCB model takes the master side.
interface frame_burst_writer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30
);
    logic                  s_valid;
    logic [DATA_W-1:0]     s_data;
    logic                  s_last;
    logic                  s_ready;
    logic                  p_wr_en;
    logic [DATA_W-1:0]     p_wr_data;
    logic [DATA_W/8-1:0]   p_wr_mask;
    logic                  p_wr_full;
    logic                  p_cmd_en;
    logic [2:0]            p_cmd_instr;
    logic [5:0]            p_cmd_bl;
    logic [ADDR_W-1:0]     p_cmd_byte_addr;
    logic                  p_cmd_full;

    modport master (
        output s_valid, s_data, s_last, p_wr_full, p_cmd_full,
        input  s_ready, p_wr_en, p_wr_data, p_wr_mask,
               p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr
    );

    modport slave (
        input  s_valid, s_data, s_last, p_wr_full, p_cmd_full,
        output s_ready, p_wr_en, p_wr_data, p_wr_mask,
               p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr
    );
endinterface

// File: rtl/frame_burst_writer.sv
// Render-to-DDR write path: packs pixel words into MCB write bursts at an
// auto-incrementing byte address that wraps to BASE_ADDR at every frame end.
module frame_burst_writer #(
    parameter int          DATA_W      = 32,
    parameter int          BURST_LEN   = 32,
    parameter int          FRAME_WORDS = 307200,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int          ADDR_W      = 30
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 calib_done,
    frame_burst_writer_if.slave  bus,
    output logic                 frame_done,
    output logic [15:0]          frame_count,
    output logic                 err_sync
);
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int WORD_W = $clog2(FRAME_WORDS + 1);
    localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {WAIT_CAL, FILL, DRAIN, CMD} state_t;

    state_t              state, state_nxt;
    logic [BEAT_W-1:0]   beat, beat_inc;
    logic [WORD_W-1:0]   word, word_inc;
    logic [ADDR_W-1:0]   addr;
    logic                last_seen, count_hit;
    logic                accept, close_burst, issue, frame_end;

    assign accept      = (state == FILL) && bus.s_valid && bus.s_ready;
    assign beat_inc    = beat + BEAT_W'(1);
    assign word_inc    = word + WORD_W'(1);
    assign close_burst = (beat_inc == BEAT_W'(BURST_LEN)) ||
                         (word_inc == WORD_W'(FRAME_WORDS)) || bus.s_last;

    // The two end-of-frame causes are latched at burst close so the command
    // cycle can tell a clean frame end from a short or overlong one.
    assign frame_end = last_seen || count_hit;

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        case (state)
            WAIT_CAL: if (calib_done) state_nxt = FILL;
            FILL:     if (accept && close_burst) state_nxt = DRAIN;
            DRAIN:    state_nxt = CMD;
            CMD: begin
                if (!bus.p_cmd_full) begin
                    issue     = 1'b1;
                    state_nxt = FILL;
                end
            end
            default:  state_nxt = WAIT_CAL;
        endcase
    end

    assign bus.p_cmd_en    = issue;
    assign bus.p_cmd_instr = 3'b000;
    assign bus.p_wr_mask   = '0;
    assign frame_done      = issue && frame_end;
    assign err_sync        = issue && (last_seen != count_hit);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state               <= WAIT_CAL;
            bus.s_ready         <= 1'b0;
            bus.p_wr_en         <= 1'b0;
            bus.p_wr_data       <= '0;
            bus.p_cmd_bl        <= '0;
            bus.p_cmd_byte_addr <= BASE;
            frame_count         <= '0;
            addr                <= BASE;
            beat                <= '0;
            word                <= '0;
            last_seen           <= 1'b0;
            count_hit           <= 1'b0;
        end else begin
            state       <= state_nxt;
            bus.s_ready <= (state_nxt == FILL) && !bus.p_wr_full;
            bus.p_wr_en <= accept;
            if (accept) begin
                bus.p_wr_data <= bus.s_data;
                beat          <= beat_inc;
                word          <= word_inc;
                if (close_burst) begin
                    last_seen <= bus.s_last;
                    count_hit <= (word_inc == WORD_W'(FRAME_WORDS));
                end
            end
            if (state == DRAIN) begin
                bus.p_cmd_bl        <= 6'(beat - BEAT_W'(1));
                bus.p_cmd_byte_addr <= addr;
            end
            if (issue) begin
                beat <= '0;
                if (frame_end) begin
                    addr        <= BASE;
                    word        <= '0;
                    frame_count <= frame_count + 16'd1;
                end else begin
                    addr <= addr + ADDR_W'(beat) * WORD_BYTES;
                end
            end
        end
    end
endmodule

// File: tb/tb_frame_burst_writer.sv
// Scoreboard bench for frame_burst_writer: one instance with default frame size,
// one with a 40-word frame for wrap, short-frame, long-frame and reset cases.
module tb_frame_burst_writer;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 30;

    typedef struct {
        int                 sel;
        logic [DATA_W-1:0]  data;
    } wr_t;

    typedef struct {
        int                 sel;
        logic [5:0]         bl;
        logic [ADDR_W-1:0]  addr;
        logic               fd;
        logic               es;
        int                 gap;
    } cmd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic resetn_a, resetn_b, calib_a, calib_b;
    logic fd_a, fd_b, es_a, es_b;
    logic [15:0] fc_a, fc_b;

    int checks = 0;
    int failures = 0;
    int neg_cnt = 0;
    int last_acc [2];
    int full_acc [2];
    int ready_seen;
    wr_t  exp_data[$];
    cmd_t exp_cmd[$];

    frame_burst_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_a ();
    frame_burst_writer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b ();

    frame_burst_writer #(
        .DATA_W(DATA_W), .BURST_LEN(32), .FRAME_WORDS(307200), .BASE_ADDR(0), .ADDR_W(ADDR_W)
    ) dut_a (
        .clk(clk), .resetn(resetn_a), .calib_done(calib_a), .bus(if_a),
        .frame_done(fd_a), .frame_count(fc_a), .err_sync(es_a)
    );

    frame_burst_writer #(
        .DATA_W(DATA_W), .BURST_LEN(32), .FRAME_WORDS(40), .BASE_ADDR(0), .ADDR_W(ADDR_W)
    ) dut_b (
        .clk(clk), .resetn(resetn_b), .calib_done(calib_b), .bus(if_b),
        .frame_done(fd_b), .frame_count(fc_b), .err_sync(es_b)
    );

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic fail_now(input string msg);
        checks++;
        failures++;
        $display("[TB] FAIL %s", msg);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic v, input logic [DATA_W-1:0] d, input logic l);
        if (sel == 0) begin
            if_a.s_valid = v; if_a.s_data = d; if_a.s_last = l;
        end else begin
            if_b.s_valid = v; if_b.s_data = d; if_b.s_last = l;
        end
    endtask

    // Called at the start of a cycle; holds the word valid until it is taken.
    task automatic apply_stimulus(input int sel, input logic [DATA_W-1:0] data, input logic last);
        logic rdy;
        for (int t = 0; t < 200; t++) begin
            drive(sel, 1'b1, data, last);
            @(negedge clk);
            rdy = (sel == 0) ? if_a.s_ready : if_b.s_ready;
            if (rdy) begin
                exp_data.push_back('{sel, data});
                sync();
                drive(sel, 1'b0, '0, 1'b0);
                return;
            end
            sync();
        end
        drive(sel, 1'b0, '0, 1'b0);
        fail_now($sformatf("s_ready_timeout dut=%0d data=%h actual=never_ready required=ready", sel, data));
    endtask

    task automatic expect_cmd(input int sel, input logic [5:0] bl, input logic [ADDR_W-1:0] addr,
                              input logic fd, input logic es, input int gap);
        exp_cmd.push_back('{sel, bl, addr, fd, es, gap});
    endtask

    task automatic wait_drain();
        int t = 0;
        while ((exp_cmd.size() != 0 || exp_data.size() != 0) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_cmd.size() != 0 || exp_data.size() != 0)
            fail_now($sformatf("drain_timeout pending_cmd=%0d pending_data=%0d required 0",
                               exp_cmd.size(), exp_data.size()));
        repeat (3) @(negedge clk);
        sync();
    endtask

    task automatic monitor_step(input int sel, input logic acc, input logic wr_full,
                                input logic wr_en, input logic [DATA_W-1:0] wr_data,
                                input logic cmd_en, input logic cmd_full, input logic [5:0] bl,
                                input logic [ADDR_W-1:0] addr, input logic fd, input logic es);
        wr_t  w;
        cmd_t c;
        if (acc) begin
            last_acc[sel] = neg_cnt;
            if (wr_full) full_acc[sel]++;
        end
        if (wr_en) begin
            if (exp_data.size() == 0 || exp_data[0].sel != sel) begin
                fail_now($sformatf("wr_unexpected dut=%0d actual=%h required=no_write", sel, wr_data));
            end else begin
                w = exp_data.pop_front();
                check_output($sformatf("dut%0d_wr_data", sel), 64'(wr_data), 64'(w.data));
            end
        end
        if (cmd_en) begin
            check_output($sformatf("dut%0d_cmd_while_full", sel), 64'(cmd_full), 64'(0));
            if (exp_cmd.size() == 0 || exp_cmd[0].sel != sel) begin
                fail_now($sformatf("cmd_unexpected dut=%0d actual bl=%0d addr=%h required=no_cmd", sel, bl, addr));
            end else begin
                c = exp_cmd.pop_front();
                check_output($sformatf("dut%0d_cmd_bl", sel), 64'(bl), 64'(c.bl));
                check_output($sformatf("dut%0d_cmd_addr", sel), 64'(addr), 64'(c.addr));
                check_output($sformatf("dut%0d_frame_done", sel), 64'(fd), 64'(c.fd));
                check_output($sformatf("dut%0d_err_sync", sel), 64'(es), 64'(c.es));
                if (c.gap >= 0)
                    check_output($sformatf("dut%0d_cmd_latency", sel), 64'(neg_cnt - last_acc[sel]), 64'(c.gap));
            end
        end else if (fd || es) begin
            fail_now($sformatf("strobe_without_cmd dut=%0d actual fd=%0b es=%0b required=0", sel, fd, es));
        end
    endtask

    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            neg_cnt++;
            monitor_step(0, if_a.s_valid && if_a.s_ready, if_a.p_wr_full, if_a.p_wr_en, if_a.p_wr_data,
                         if_a.p_cmd_en, if_a.p_cmd_full, if_a.p_cmd_bl, if_a.p_cmd_byte_addr, fd_a, es_a);
            monitor_step(1, if_b.s_valid && if_b.s_ready, if_b.p_wr_full, if_b.p_wr_en, if_b.p_wr_data,
                         if_b.p_cmd_en, if_b.p_cmd_full, if_b.p_cmd_bl, if_b.p_cmd_byte_addr, fd_b, es_b);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        last_acc = '{0, 0};
        full_acc = '{0, 0};
        resetn_a = 1'b0; resetn_b = 1'b0; calib_a = 1'b0; calib_b = 1'b0;
        drive(0, 1'b0, '0, 1'b0);
        drive(1, 1'b0, '0, 1'b0);
        if_a.p_wr_full = 1'b0; if_a.p_cmd_full = 1'b0;
        if_b.p_wr_full = 1'b0; if_b.p_cmd_full = 1'b0;
        fork
            monitor_loop();
        join_none

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_s_ready", 64'(if_a.s_ready), 64'(0));
        check_output("rst_wr_en", 64'(if_a.p_wr_en), 64'(0));
        check_output("rst_wr_data", 64'(if_a.p_wr_data), 64'(0));
        check_output("rst_wr_mask", 64'(if_a.p_wr_mask), 64'(0));
        check_output("rst_cmd_en", 64'(if_a.p_cmd_en), 64'(0));
        check_output("rst_cmd_instr", 64'(if_a.p_cmd_instr), 64'(0));
        check_output("rst_cmd_bl", 64'(if_a.p_cmd_bl), 64'(0));
        check_output("rst_cmd_addr", 64'(if_a.p_cmd_byte_addr), 64'(0));
        check_output("rst_frame_done", 64'(fd_a), 64'(0));
        check_output("rst_err_sync", 64'(es_a), 64'(0));
        check_output("rst_frame_count", 64'(fc_a), 64'(0));
        sync();
        resetn_a = 1'b1; resetn_b = 1'b1;

        // Calibration gate
        ready_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (if_a.s_ready) ready_seen++;
        end
        check_output("ready_before_cal", 64'(ready_seen), 64'(0));
        sync();
        calib_a = 1'b1; calib_b = 1'b1;
        @(negedge clk);
        check_output("ready_cal_cycle", 64'(if_a.s_ready), 64'(0));
        @(negedge clk);
        check_output("ready_after_cal", 64'(if_a.s_ready), 64'(1));
        sync();

        // Two full bursts at default size
        expect_cmd(0, 6'd31, 30'h0,  1'b0, 1'b0, 2);
        expect_cmd(0, 6'd31, 30'h80, 1'b0, 1'b0, 2);
        for (int i = 0; i < 64; i++) apply_stimulus(0, 32'hA000_0000 + 32'(i), 1'b0);
        wait_drain();

        // Clean 40-word frame with s_last on word 40
        expect_cmd(1, 6'd31, 30'h0,  1'b0, 1'b0, 2);
        expect_cmd(1, 6'd7,  30'h80, 1'b1, 1'b0, 2);
        for (int i = 1; i <= 40; i++) apply_stimulus(1, 32'h1000_0000 + 32'(i), i == 40);
        wait_drain();
        check_output("frame_count_wrap", 64'(fc_b), 64'(1));

        // Short frame: s_last on word 10
        expect_cmd(1, 6'd9, 30'h0, 1'b1, 1'b1, 2);
        for (int i = 1; i <= 10; i++) apply_stimulus(1, 32'h2000_0000 + 32'(i), i == 10);
        wait_drain();
        check_output("frame_count_short", 64'(fc_b), 64'(2));

        // Long frame: 40 words without s_last
        expect_cmd(1, 6'd31, 30'h0,  1'b0, 1'b0, 2);
        expect_cmd(1, 6'd7,  30'h80, 1'b1, 1'b1, 2);
        for (int i = 1; i <= 40; i++) apply_stimulus(1, 32'h3000_0000 + 32'(i), 1'b0);
        wait_drain();
        check_output("frame_count_long", 64'(fc_b), 64'(3));

        // Write FIFO backpressure for 5 cycles mid-burst
        full_acc[0] = 0;
        expect_cmd(0, 6'd31, 30'h100, 1'b0, 1'b0, 2);
        fork
            for (int i = 0; i < 32; i++) apply_stimulus(0, 32'hB000_0000 + 32'(i), 1'b0);
            begin
                repeat (8) @(posedge clk);
                #1 if_a.p_wr_full = 1'b1;
                repeat (5) @(posedge clk);
                #1 if_a.p_wr_full = 1'b0;
            end
        join
        wait_drain();
        check_output("accepts_while_wr_full", 64'(full_acc[0]), 64'(1));

        // Command FIFO full holds the command until it clears
        if_a.p_cmd_full = 1'b1;
        expect_cmd(0, 6'd31, 30'h180, 1'b0, 1'b0, 4);
        for (int i = 0; i < 32; i++) apply_stimulus(0, 32'hC000_0000 + 32'(i), 1'b0);
        repeat (3) sync();
        if_a.p_cmd_full = 1'b0;
        wait_drain();

        // Reset mid-burst discards the partial burst
        for (int i = 0; i < 12; i++) apply_stimulus(1, 32'hD000_0000 + 32'(i), 1'b0);
        resetn_b = 1'b0; calib_b = 1'b0;
        repeat (3) sync();
        @(negedge clk);
        check_output("midrst_frame_count", 64'(fc_b), 64'(0));
        sync();
        resetn_b = 1'b1;
        repeat (4) sync();
        @(negedge clk);
        check_output("midrst_ready_nocal", 64'(if_b.s_ready), 64'(0));
        sync();
        calib_b = 1'b1;
        expect_cmd(1, 6'd4, 30'h0, 1'b1, 1'b1, 2);
        for (int i = 1; i <= 5; i++) apply_stimulus(1, 32'hE000_0000 + 32'(i), i == 5);
        wait_drain();
        check_output("midrst_frame_count_after", 64'(fc_b), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_burst_writer.md
# frame_burst_writer

Parametrised successor to the single-port render-to-DDR write path. Accepts a stream of pixel words from a rendering engine over a valid/ready handshake and forwards them into one MCB user write port. It groups words into bursts of up to BURST_LEN, issues one write command per burst at an auto-incrementing byte address, and wraps to the frame base at end of frame. Sits between the render engine and the DDR2 controller, on the memory user clock.

## Interface
Parameters:
- DATA_W, 32, pixel word width; multiple of 8, at most 128
- BURST_LEN, 32, maximum words per write command; 1..64
- FRAME_WORDS, 307200, words per frame (640x480); at least 1
- BASE_ADDR, 0, frame base byte address; aligned to DATA_W/8
- ADDR_W, 30, MCB byte-address width

Ports:
- clk  in  1  single clock for all logic
- resetn  in  1  reset; synchronous, active-low
- calib_done  in  1  MCB calibration complete
- s_valid  in  1  pixel word valid
- s_data  in  DATA_W  pixel word
- s_last  in  1  producer marks last word of frame
- s_ready  out  1  block accepts word this cycle
- p_wr_en  out  1  MCB write-FIFO push
- p_wr_data  out  DATA_W  MCB write data
- p_wr_mask  out  DATA_W/8  write mask, constant 0
- p_wr_full  in  1  MCB write FIFO full
- p_cmd_en  out  1  MCB command push
- p_cmd_instr  out  3  command, constant 3'b000 (write)
- p_cmd_bl  out  6  burst length minus 1
- p_cmd_byte_addr  out  ADDR_W  burst start byte address
- p_cmd_full  in  1  MCB command FIFO full
- frame_done  out  1  one-cycle pulse when the frame's last command issues
- frame_count  out  16  completed frames, wraps at 65535 -> 0
- err_sync  out  1  one-cycle pulse: s_last disagrees with word count

## Operation
- States: WAIT_CAL, FILL, DRAIN, CMD.
- WAIT_CAL: s_ready=0. Move to FILL when calib_done=1.
- FILL: s_ready = !p_wr_full. A word is accepted when s_valid and s_ready are both high. On acceptance, register the word into p_wr_data, set p_wr_en=1 on the next cycle, and increment beat (burst word count) and word (frame word count).
- Burst closes on the accepting cycle when any of these holds: beat reaches BURST_LEN; word reaches FRAME_WORDS; s_last=1. Then move to DRAIN.
- DRAIN: lasts one cycle, so the final p_wr_en lands before the command. Move to CMD.
- CMD: hold p_cmd_en=0 while p_cmd_full=1. Otherwise pulse p_cmd_en for one cycle with p_cmd_bl=beat-1 and p_cmd_byte_addr=addr. Then:
  - addr += beat*DATA_W/8, truncated to ADDR_W.
  - beat clears; return to FILL.
- End of frame, when word==FRAME_WORDS or s_last closed the burst:
  - addr <- BASE_ADDR, word <- 0.
  - frame_done pulses with p_cmd_en; frame_count increments.
- err_sync pulses in the CMD issue cycle when either:
  - s_last=1 with word<FRAME_WORDS (short frame; still wraps), or
  - word==FRAME_WORDS without s_last (long/missing last; still wraps).
- A burst never crosses a frame boundary. A frame-final burst may be shorter than BURST_LEN.
- calib_done deassertion mid-operation is ignored; only reset returns the block to WAIT_CAL.

## Timing
- Reset (resetn=0 at a clk edge) sets:
  - state=WAIT_CAL; s_ready, p_wr_en, p_cmd_en, frame_done, err_sync = 0.
  - p_wr_data, p_cmd_bl = 0; p_cmd_byte_addr = BASE_ADDR; frame_count = 0; internal addr=BASE_ADDR, beat=0, word=0.
- Reset mid-burst discards the partial burst and issues no command.
- Word accepted at cycle N: p_wr_en/p_wr_data valid at N+1.
- Burst-closing word at N: DRAIN at N+1 (its p_wr_en also high at N+1). Earliest p_cmd_en at N+2. Earliest next acceptance at N+3.
- s_ready is a registered function of state and the current p_wr_full; it drops the cycle after p_wr_full rises. The MCB FIFO's headroom covers the single overrun word.
- Throughput: a full burst takes BURST_LEN+2 cycles without stalls.

## Test plan
- Reset and calibration: hold calib_done=0 for 20 cycles -> s_ready stays 0; raise calib_done -> s_ready=1 the next cycle.
- Full bursts, defaults: stream 64 words, s_valid constant -> two commands: bl=31 at addr 0x0, then bl=31 at addr 0x80; each p_cmd_en exactly 2 cycles after the 32nd word of its burst.
- Frame wrap, FRAME_WORDS=40, BURST_LEN=32, s_last on word 40 -> commands (bl=31, 0x0) and (bl=7, 0x80); frame_done pulses with the second; frame_count=1; the next word's burst starts at 0x0; err_sync never pulses.
- Short frame: s_last on word 10 with FRAME_WORDS=40 -> one command bl=9 at 0x0; err_sync=1 and frame_done=1 in the same cycle; addr returns to 0x0.
- Backpressure: p_wr_full high for 5 cycles mid-burst -> no more than one word accepted after the rise; data order intact. p_cmd_full high in CMD -> p_cmd_en waits and fires the cycle after it falls.
- Reset mid-burst after 12 words -> no p_cmd_en. After calib_done is reasserted, the first command uses addr=BASE_ADDR, and frame_count=0.
